// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the tinyriscv instruction path.
// Contents:
//   InstAddrBus / InstBus  32-bit instruction address and instruction word types
//   INST_NOP               word presented to the fetch unit when nothing is buffered
//   pf_state_e             prefetcher FSM states
//   word_align()           clears the byte-offset bits of an address
package tinyriscv_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam InstBus INST_NOP = 32'h0000_0001;

    typedef enum logic [1:0] {
        PF_IDLE   = 2'd0,
        PF_FETCH  = 2'd1,
        PF_HALTED = 2'd2
    } pf_state_e;

    // Instruction addresses are always word aligned; bits [1:0] are forced to zero.
    function automatic InstAddrBus word_align(input InstAddrBus addr);
        word_align = addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO holding prefetched instruction words tagged with their word address.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   clear_i          empties the FIFO (has priority over push and pop)
//   push_i, data_i   write one entry (ignored when full)
//   pop_i            drop the head entry (ignored when empty)
//   head_o           head entry, valid only when empty_o = 0
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries (0..DEPTH)
module instr_prefetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 62
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == CNT_W'(0));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !clear_i && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues in-order word reads on the instruction memory bus,
// buffers the returned words and presents the head word to the fetch unit.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i, flush_addr_i        discard everything and restart at flush_addr_i (word aligned)
//   halt_i                       stop issuing new requests
//   consume_i                    fetch unit takes the head word
//   instr_o, instr_addr_o        head word and its address (INST_NOP / 0 when empty)
//   instr_valid_o                buffer not empty
//   mem_req_o, mem_addr_o        read request and its word address
//   mem_gnt_i                    request accepted
//   mem_rvalid_i, mem_rdata_i    in-order read response
module instr_prefetch
    import tinyriscv_pkg::*;
#(
    parameter int         DEPTH     = 2,
    parameter InstAddrBus BOOT_ADDR = 32'h0000_0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  InstAddrBus flush_addr_i,
    input  logic       halt_i,
    input  logic       consume_i,
    output InstBus     instr_o,
    output InstAddrBus instr_addr_o,
    output logic       instr_valid_o,
    output logic       mem_req_o,
    output InstAddrBus mem_addr_o,
    input  logic       mem_gnt_i,
    input  logic       mem_rvalid_i,
    input  InstBus     mem_rdata_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Stale responses from back-to-back flushes can stack beyond DEPTH, so the
    // discard counter carries one extra bit of headroom.
    localparam int DISC_W = CNT_W + 1;
    localparam int FIFO_W = 30 + 32;

    pf_state_e         state_q, state_d;
    InstAddrBus        addr_q, addr_d;
    logic [29:0]       resp_word_q, resp_word_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [DISC_W-1:0] disc_q, disc_d;

    logic              req_s;
    logic              gnt_s;
    logic              push_s;
    logic              pop_s;
    logic              cap_ok_s;
    logic [CNT_W:0]    in_flight_s;
    logic [FIFO_W-1:0] fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    assign in_flight_s = {1'b0, fifo_count_s} + {1'b0, out_q};
    assign cap_ok_s    = (in_flight_s < (CNT_W + 1)'(DEPTH));
    assign gnt_s       = req_s && mem_gnt_i;
    // Responses are dropped while older (pre-flush) reads are still returning.
    assign push_s      = mem_rvalid_i && !flush_i && (disc_q == DISC_W'(0)) && !fifo_full_s;
    assign pop_s       = consume_i && !fifo_empty_s && !flush_i;

    instr_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .push_i  (push_s),
        .data_i  ({resp_word_q, mem_rdata_i}),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A request already on the bus is held until granted, so
    // halting waits for that grant before leaving FETCH.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = halt_i ? PF_HALTED : PF_FETCH;
        end else begin
            case (state_q)
                PF_IDLE:   state_d = PF_FETCH;
                PF_FETCH:  state_d = (halt_i && !(req_s && !mem_gnt_i)) ? PF_HALTED : PF_FETCH;
                PF_HALTED: state_d = halt_i ? PF_HALTED : PF_FETCH;
                default:   state_d = PF_IDLE;
            endcase
        end
    end

    // FSM outputs: request whenever fetching and buffer + in-flight reads leave room.
    always_comb begin
        req_s = 1'b0;
        if ((state_q == PF_FETCH) && !flush_i && cap_ok_s) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Next request address and next expected response address.
    always_comb begin
        addr_d      = addr_q;
        resp_word_d = resp_word_q;
        if (flush_i) begin
            addr_d      = word_align(flush_addr_i);
            resp_word_d = flush_addr_i[31:2];
        end else begin
            addr_d      = gnt_s ? (addr_q + 32'd4) : addr_q;
            resp_word_d = push_s ? (resp_word_q + 30'd1) : resp_word_q;
        end
    end

    // Outstanding / discard bookkeeping. On flush every read still in flight,
    // including this cycle's grant, becomes stale; this cycle's response retires one.
    always_comb begin
        out_d  = out_q;
        disc_d = disc_q;
        if (flush_i) begin
            out_d  = '0;
            disc_d = disc_q + DISC_W'(out_q) + DISC_W'(gnt_s) - DISC_W'(mem_rvalid_i);
        end else begin
            case ({gnt_s, push_s})
                2'b10:   out_d = out_q + CNT_W'(1);
                2'b01:   out_d = out_q - CNT_W'(1);
                default: out_d = out_q;
            endcase
            if (mem_rvalid_i && (disc_q != DISC_W'(0))) begin
                disc_d = disc_q - DISC_W'(1);
            end else begin
                disc_d = disc_q;
            end
        end
    end

    // Address and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= word_align(BOOT_ADDR);
            resp_word_q <= BOOT_ADDR[31:2];
            out_q       <= '0;
            disc_q      <= '0;
        end else begin
            addr_q      <= addr_d;
            resp_word_q <= resp_word_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
        end
    end

    // Fetch-side outputs come straight from the FIFO registers.
    always_comb begin
        instr_valid_o = !fifo_empty_s;
        instr_o       = INST_NOP;
        instr_addr_o  = 32'h0000_0000;
        if (!fifo_empty_s) begin
            instr_o      = fifo_head_s[31:0];
            instr_addr_o = {fifo_head_s[61:32], 2'b00};
        end else begin
            instr_o      = INST_NOP;
            instr_addr_o = 32'h0000_0000;
        end
    end

    assign mem_req_o  = req_s;
    assign mem_addr_o = addr_q;

endmodule
